// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the sequential RV64 core.
// Steps FETCH/DECODE/EXEC/MEM/WB and drives datapath enables and selects.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_to_reg,
  output logic        halted,
  output logic [31:0] retired
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    C_R, C_LD, C_SD, C_BEQ
  } cls_e;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic        halted_q, halted_d;
  logic [31:0] retired_q, retired_d;

  logic        legal;
  cls_e        dec_cls;
  logic        retire;

  always_comb begin
    legal   = 1'b1;
    dec_cls = C_R;
    unique case (1'b1)
      opcode == OP_R:   dec_cls = C_R;
      opcode == OP_LD:  begin dec_cls = C_LD;  legal = (funct3 == 3'b011); end
      opcode == OP_SD:  begin dec_cls = C_SD;  legal = (funct3 == 3'b011); end
      opcode == OP_BEQ: begin dec_cls = C_BEQ; legal = (funct3 == 3'b000); end
      default:          legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    halted_d   = halted_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (legal) begin
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end else begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_EXEC: begin
        unique case (cls_q)
          C_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          C_LD, C_SD: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          default: begin
            alu_op   = 2'b01;
            pc_write = 1'b1;
            pc_src   = zero;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        alu_src = 1'b1;
        if (cls_q == C_SD) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
        end else begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (cls_q == C_LD);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    // reset masks every control output in the same cycle it is asserted
    if (reset) begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      mem_to_reg = 1'b0;
    end
    retired_d = retire ? retired_q + 32'd1 : retired_q;
  end

  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Inputs change #1 after posedge; outputs are checked right after.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_src, ir_write, reg_write;
  logic        mem_read, mem_write, alu_src, mem_to_reg;
  logic [1:0]  alu_op;
  logic        halted;
  logic [31:0] retired;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
    .halted(halted), .retired(retired)
  );

  // pw ps iw rw mr mw as op[1:0] mtr
  wire [9:0] ctl = {pc_write, pc_src, ir_write, reg_write, mem_read,
                    mem_write, alu_src, alu_op, mem_to_reg};

  localparam logic [9:0] V_ZERO   = 10'b0_0_0_0_0_0_0_00_0;
  localparam logic [9:0] V_FETCH  = 10'b0_0_1_0_0_0_0_00_0;
  localparam logic [9:0] V_R_EX   = 10'b0_0_0_0_0_0_0_10_0;
  localparam logic [9:0] V_R_WB   = 10'b1_0_0_1_0_0_0_00_0;
  localparam logic [9:0] V_BEQ_T  = 10'b1_1_0_0_0_0_0_01_0;
  localparam logic [9:0] V_BEQ_N  = 10'b1_0_0_0_0_0_0_01_0;
  localparam logic [9:0] V_MEM_EX = 10'b0_0_0_0_0_0_1_00_0;
  localparam logic [9:0] V_LD_MEM = 10'b0_0_0_0_1_0_1_00_0;
  localparam logic [9:0] V_LD_WB  = 10'b1_0_0_1_0_0_0_00_1;
  localparam logic [9:0] V_SD_W   = 10'b0_0_0_0_0_1_1_00_0;
  localparam logic [9:0] V_SD_DN  = 10'b1_0_0_0_0_1_1_00_0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; opcode = 7'b0110011; funct3 = 3'b000;
    zero = 1'b0; mem_ready = 1'b0;
    #1;
    do_reset(2);
    chk("rst_ctl", {22'd0, ctl}, {22'd0, V_ZERO});
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0; #1;
    chk("rel_fetch", {22'd0, ctl}, {22'd0, V_FETCH});

    // R-type add
    opcode = 7'b0110011; funct3 = 3'b000;
    step(); chk("r_dec", {22'd0, ctl}, {22'd0, V_ZERO});
    step(); chk("r_exec", {22'd0, ctl}, {22'd0, V_R_EX});
    step(); chk("r_wb", {22'd0, ctl}, {22'd0, V_R_WB});
    chk("r_ret_pre", retired, 32'd0);
    step(); chk("r_fetch", {22'd0, ctl}, {22'd0, V_FETCH});
    chk("r_ret", retired, 32'd1);

    // beq taken
    opcode = 7'b1100011; funct3 = 3'b000;
    step(); chk("bt_dec", {22'd0, ctl}, {22'd0, V_ZERO});
    step(); zero = 1'b1; #1;
    chk("bt_exec", {22'd0, ctl}, {22'd0, V_BEQ_T});
    step(); zero = 1'b0;
    chk("bt_fetch", {22'd0, ctl}, {22'd0, V_FETCH});
    chk("bt_ret", retired, 32'd2);

    // beq not taken
    step(); step();
    chk("bn_exec", {22'd0, ctl}, {22'd0, V_BEQ_N});
    step(); chk("bn_fetch", {22'd0, ctl}, {22'd0, V_FETCH});
    chk("bn_ret", retired, 32'd3);

    // ld with two wait cycles; mem_ready high outside MEM is ignored
    opcode = 7'b0000011; funct3 = 3'b011; mem_ready = 1'b1;
    step(); step(); mem_ready = 1'b0;
    chk("ld_exec", {22'd0, ctl}, {22'd0, V_MEM_EX});
    step(); chk("ld_mem0", {22'd0, ctl}, {22'd0, V_LD_MEM});
    step(); chk("ld_mem1", {22'd0, ctl}, {22'd0, V_LD_MEM});
    step(); mem_ready = 1'b1;
    chk("ld_mem2", {22'd0, ctl}, {22'd0, V_LD_MEM});
    step(); mem_ready = 1'b0;
    chk("ld_wb", {22'd0, ctl}, {22'd0, V_LD_WB});
    chk("ld_ret_pre", retired, 32'd3);
    step(); chk("ld_fetch", {22'd0, ctl}, {22'd0, V_FETCH});
    chk("ld_ret", retired, 32'd4);

    // sd with no wait
    opcode = 7'b0100011; funct3 = 3'b011; mem_ready = 1'b1;
    step(); step(); step();
    chk("sd_mem", {22'd0, ctl}, {22'd0, V_SD_DN});
    step(); mem_ready = 1'b0;
    chk("sd_fetch", {22'd0, ctl}, {22'd0, V_FETCH});
    chk("sd_ret", retired, 32'd5);

    // illegal opcode
    opcode = 7'b1111111; funct3 = 3'b000;
    step(); chk("ill_dec", {22'd0, ctl}, {22'd0, V_ZERO});
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ill_halt_ctl", {22'd0, ctl}, {22'd0, V_ZERO});
      chk("ill_halted", {31'd0, halted}, 32'd1);
    end
    chk("ill_ret", retired, 32'd5);
    do_reset(1);
    chk("ill_clr", {31'd0, halted}, 32'd0);
    reset = 1'b0; #1;
    chk("ill_fetch", {22'd0, ctl}, {22'd0, V_FETCH});

    // ld opcode with bad funct3
    opcode = 7'b0000011; funct3 = 3'b000;
    step(); step();
    chk("ldbad_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ldbad_ctl", {22'd0, ctl}, {22'd0, V_ZERO});
    end
    do_reset(1);
    chk("ldbad_clr", {31'd0, halted}, 32'd0);
    reset = 1'b0; #1;

    // sd abandoned by reset during the second MEM wait cycle
    opcode = 7'b0100011; funct3 = 3'b011; mem_ready = 1'b0;
    step(); step(); step();
    chk("sdr_mem0", {22'd0, ctl}, {22'd0, V_SD_W});
    step();
    chk("sdr_mem1", {22'd0, ctl}, {22'd0, V_SD_W});
    reset = 1'b1; #1;
    chk("sdr_rst_ctl", {22'd0, ctl}, {22'd0, V_ZERO});
    step();
    chk("sdr_after", {22'd0, ctl}, {22'd0, V_ZERO});
    chk("sdr_ret", retired, 32'd0);
    reset = 1'b0; #1;
    chk("sdr_fetch", {22'd0, ctl}, {22'd0, V_FETCH});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
